// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Sequences the 5-stage Otter pipeline. Hazard-unit flags and the instruction
// and data memory handshakes are turned into per-stage write-enables and
// flushes for the PC, IF/DE, DE/EX, EX/MEM and MEM/WB registers. Stall cycles
// and accepted control-hazard flushes are counted in saturating counters.
//
// Parameters
//   INIT_CYCLES   full-flush cycles after reset (1..15)
//   DMEM_TIMEOUT  DWAIT cycles before a data access is abandoned (1..255)
//   CNT_W         width of the performance counters
//
// Ports
//   CLK, RST      clock (rising edge) and synchronous active-high reset
//   load_use_haz  load in EX feeds an operand of the instruction in DE
//   control_haz   jal/jalr/taken branch resolved in EX
//   imem_ready    fetch at current PC is valid (held until pc_we)
//   dmem_req      MEM stage holds a load/store
//   dmem_ready    data memory completes the MEM-stage access this cycle
//   *_we          per-register write enables (combinational)
//   *_flush       per-register NOP loads, override the write enable
//   dmem_err      sticky data-access timeout flag
//   stall_cnt     non-INIT cycles with pc_we=0 (saturating)
//   flush_cnt     accepted control hazards (saturating)
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int unsigned INIT_CYCLES  = 5,
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_use_haz,
    input  logic             control_haz,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DWAIT,
        ST_DISCARD
    } state_t;

    localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0]       TMO_LIMIT = 8'(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             dmem_err_q, dmem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;   // MEM stage is waiting on data memory this cycle
    logic freeze;      // hold PC..EX/MEM, bubble into MEM/WB
    logic run_rules;   // evaluate the control/load-use/fetch rules
    logic ctrl_taken;  // a control hazard was accepted this cycle

    assign mem_stall = dmem_req & ~dmem_ready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        pc_we        = 1'b1;
        if_de_we     = 1'b1;
        de_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_de_flush  = 1'b0;
        de_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        dmem_err_d   = dmem_err_q;
        freeze       = 1'b0;
        run_rules    = 1'b0;
        ctrl_taken   = 1'b0;

        case (state_q)
            ST_INIT: begin
                pc_we        = 1'b0;
                if_de_we     = 1'b0;
                de_ex_we     = 1'b0;
                ex_mem_we    = 1'b0;
                mem_wb_we    = 1'b0;
                if_de_flush  = 1'b1;
                de_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 4'd0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    freeze    = 1'b1;
                    state_d   = ST_DWAIT;
                    tmo_cnt_d = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_DWAIT: begin
                if (!dmem_ready) begin
                    // Hazards are ignored while frozen; they are re-presented
                    // by the hazard unit once the pipeline moves again.
                    freeze = 1'b1;
                    if (tmo_cnt_q == TMO_LIMIT) begin
                        dmem_err_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end else begin
                    state_d   = ST_RUN;
                    run_rules = 1'b1;
                end
            end
            ST_DISCARD: begin
                // Wrong-path fetch in flight: keep PC on the target and drop
                // whatever word comes back.
                pc_we       = 1'b0;
                if_de_flush = 1'b1;
                if (mem_stall) begin
                    freeze = 1'b1;
                end else if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (run_rules) begin
            if (control_haz) begin
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
                ctrl_taken  = 1'b1;
                if (!imem_ready) begin
                    state_d = ST_DISCARD;
                end
            end else if (load_use_haz) begin
                pc_we       = 1'b0;
                if_de_we    = 1'b0;
                de_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_we       = 1'b0;
                if_de_flush = 1'b1;
            end
        end

        if (freeze) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_INIT) && !pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end

        flush_cnt_d = flush_cnt_q;
        if (ctrl_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 4'd0;
            tmo_cnt_q   <= 8'd0;
            dmem_err_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            dmem_err_q  <= dmem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign dmem_err  = dmem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed vectors for pipeline_stall_ctrl. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a separate monitor pops one
// entry per cycle on the falling edge and compares.
// DUT built with INIT_CYCLES=5, DMEM_TIMEOUT=4, CNT_W=4 so timeout and
// counter saturation are reachable quickly.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    // Expected stage-control vectors:
    // {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
    //  if_de_flush, de_ex_flush, ex_mem_flush, mem_wb_flush}
    localparam logic [8:0] C_INIT     = 9'b00000_1111;
    localparam logic [8:0] C_RUN      = 9'b11111_0000;
    localparam logic [8:0] C_LU       = 9'b00111_0100;
    localparam logic [8:0] C_CTRL     = 9'b11111_1100;
    localparam logic [8:0] C_NOIMEM   = 9'b01111_1000;
    localparam logic [8:0] C_DISC     = 9'b01111_1000;
    localparam logic [8:0] C_FRZ      = 9'b00001_0001;
    localparam logic [8:0] C_DISC_FRZ = 9'b00001_1001;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          load_use_haz = 1'b0;
    logic          control_haz  = 1'b0;
    logic          imem_ready   = 1'b1;
    logic          dmem_req     = 1'b0;
    logic          dmem_ready   = 1'b0;
    logic          pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
    logic          if_de_flush, de_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          dmem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_stall_ctrl #(
        .INIT_CYCLES (5),
        .DMEM_TIMEOUT(4),
        .CNT_W       (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .load_use_haz(load_use_haz),
        .control_haz (control_haz),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .if_de_we    (if_de_we),
        .de_ex_we    (de_ex_we),
        .ex_mem_we   (ex_mem_we),
        .mem_wb_we   (mem_wb_we),
        .if_de_flush (if_de_flush),
        .de_ex_flush (de_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .dmem_err    (dmem_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string         name;
        logic [8:0]    ctl;
        logic          err;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during it.
    // Entered and left just after a rising edge.
    task automatic step(input string name, input logic rst, input logic lu,
                        input logic ch, input logic imr, input logic dreq,
                        input logic drdy, input logic [8:0] ctl,
                        input logic err, input int stall, input int flush);
        exp_t e;
        RST          = rst;
        load_use_haz = lu;
        control_haz  = ch;
        imem_ready   = imr;
        dmem_req     = dreq;
        dmem_ready   = drdy;
        e.name  = name;
        e.ctl   = ctl;
        e.err   = err;
        e.stall = CW'(stall);
        e.flush = CW'(flush);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares one queued expectation per cycle, mid-cycle.
    initial begin : monitor
        exp_t e;
        logic [8:0] ctl_act;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ctl_act = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
                           if_de_flush, de_ex_flush, ex_mem_flush, mem_wb_flush};
                check({e.name, ".ctl"},   32'(ctl_act),   32'(e.ctl));
                check({e.name, ".err"},   32'(dmem_err),  32'(e.err));
                check({e.name, ".stall"}, 32'(stall_cnt), 32'(e.stall));
                check({e.name, ".flush"}, 32'(flush_cnt), 32'(e.flush));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        @(posedge CLK);
        #1;
        // T1: second reset cycle, five INIT cycles, then RUN.
        //             name      rst lu ch im dq dr  ctl        err st fl
        step("rst",     1, 0, 0, 1, 0, 0, C_INIT,     0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("init",  0, 0, 0, 1, 0, 0, C_INIT,     0, 0, 0);
        step("run",     0, 0, 0, 1, 0, 0, C_RUN,      0, 0, 0);
        // T2: load-use stall.
        step("lu",      0, 1, 0, 1, 0, 0, C_LU,       0, 0, 0);
        step("lu_post", 0, 0, 0, 1, 0, 0, C_RUN,      0, 1, 0);
        // T3: control hazard wins over load-use.
        step("ctl_lu",  0, 1, 1, 1, 0, 0, C_CTRL,     0, 1, 0);
        step("ctl_post",0, 0, 0, 1, 0, 0, C_RUN,      0, 1, 1);
        // T4: three freeze cycles, control pulse ignored in the second.
        step("frz1",    0, 0, 0, 1, 1, 0, C_FRZ,      0, 1, 1);
        step("frz2",    0, 0, 1, 1, 1, 0, C_FRZ,      0, 2, 1);
        step("frz3",    0, 0, 0, 1, 1, 0, C_FRZ,      0, 3, 1);
        step("frz_rel", 0, 0, 0, 1, 1, 1, C_RUN,      0, 4, 1);
        step("frz_post",0, 0, 0, 1, 0, 0, C_RUN,      0, 4, 1);
        // T5: control hazard with fetch outstanding -> two DISCARD cycles.
        step("ctl_nim", 0, 0, 1, 0, 0, 0, C_CTRL,     0, 4, 1);
        step("disc1",   0, 0, 0, 0, 0, 0, C_DISC,     0, 4, 2);
        step("disc2",   0, 0, 0, 1, 0, 0, C_DISC,     0, 5, 2);
        step("disc_out",0, 0, 0, 1, 0, 0, C_RUN,      0, 6, 2);
        // Fetch miss in RUN.
        step("nimem",   0, 0, 0, 0, 0, 0, C_NOIMEM,   0, 6, 2);
        // DWAIT released with a control hazard and no fetch -> DISCARD,
        // then a data stall inside DISCARD holds the state.
        step("dw_a",    0, 0, 0, 1, 1, 0, C_FRZ,      0, 7, 2);
        step("dw_ctl",  0, 0, 1, 0, 1, 1, C_CTRL,     0, 8, 2);
        step("disc_frz",0, 0, 0, 1, 1, 0, C_DISC_FRZ, 0, 8, 3);
        step("disc_end",0, 0, 0, 1, 0, 0, C_DISC,     0, 9, 3);
        // DWAIT released with a load-use hazard.
        step("dw_b",    0, 0, 0, 1, 1, 0, C_FRZ,      0, 10, 3);
        step("dw_lu",   0, 1, 0, 1, 1, 1, C_LU,       0, 11, 3);
        step("idle",    0, 0, 0, 1, 0, 0, C_RUN,      0, 12, 3);
        // T6: data access never completes; timeout after 4 DWAIT cycles,
        // stall_cnt saturates at 15.
        step("to_run",  0, 0, 0, 1, 1, 0, C_FRZ,      0, 12, 3);
        step("to_w1",   0, 0, 0, 1, 1, 0, C_FRZ,      0, 13, 3);
        step("to_w2",   0, 0, 0, 1, 1, 0, C_FRZ,      0, 14, 3);
        step("to_w3",   0, 0, 0, 1, 1, 0, C_FRZ,      0, 15, 3);
        step("to_w4",   0, 0, 0, 1, 1, 0, C_FRZ,      0, 15, 3);
        step("to_err",  0, 0, 0, 1, 1, 0, C_FRZ,      1, 15, 3);
        step("to_stky", 0, 0, 0, 1, 1, 0, C_FRZ,      1, 15, 3);
        // Reset mid-DWAIT: outputs still reflect DWAIT during the reset cycle.
        step("to_rst",  1, 0, 0, 1, 1, 0, C_FRZ,      1, 15, 3);
        for (int i = 0; i < 5; i++)
            step("reinit",0, 0, 0, 1, 0, 0, C_INIT,     0, 0, 0);
        // flush_cnt saturation.
        for (int i = 0; i < 16; i++)
            step("fsat",  0, 0, 1, 1, 0, 0, C_CTRL,     0, 0, (i < 15) ? i : 15);
        step("fsat_end",0, 0, 0, 1, 0, 0, C_RUN,      0, 0, 15);

        @(negedge CLK);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
